// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage and the memory controller,
// plus the single-entry slot record.
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic [31:0] op;
    logic [31:0] wdata;
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        sign;
    logic        rd_vld;
    logic [3:0]  rd_code;
  } slot_t;

endpackage

// File: rtl/mem_stage_st_lane_rep.sv
// Replicates narrow store data across all byte lanes so the controller can
// pick any lane by address; reserved size 11 behaves as a word.
module mem_stage_st_lane_rep
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] wdata_o
);

  always_comb begin
    case (size_i)
      SZ_BYTE: wdata_o = {4{wdata_i[7:0]}};
      SZ_HALF: wdata_o = {2{wdata_i[15:0]}};
      default: wdata_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: one-instruction slot issuing loads/stores over req/ack,
// stalling execute until the access is accepted and feeding registered write-back.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_vld,
  output logic        o_mem_rdy,
  input  logic [31:0] i_mem_op,
  input  logic [31:0] i_mem_wdata,
  input  logic        i_mem_ld,
  input  logic        i_mem_st,
  input  logic [1:0]  i_mem_size,
  input  logic        i_mem_sign,
  input  logic        i_mem_rd_vld,
  input  logic [3:0]  i_mem_rd_code,
  output logic        o_memctrl_req,
  output logic        o_memctrl_we,
  output logic [31:0] o_memctrl_addr,
  output logic [31:0] o_memctrl_wdata,
  output logic [1:0]  o_memctrl_size,
  output logic        o_memctrl_sign,
  input  logic        i_memctrl_ack,
  input  logic        i_memctrl_abort,
  output logic [31:0] o_wb_op,
  output logic        o_wb_rd_src,
  output logic        o_wb_rd_vld,
  output logic [3:0]  o_wb_rd_code,
  output logic        o_dabort
);

  slot_t       slot_q, slot_d;
  logic        slot_vld_q;
  logic [31:0] wb_op_q;
  logic        wb_rd_src_q;
  logic        wb_rd_vld_q;
  logic [3:0]  wb_rd_code_q;
  logic        dabort_q;

  logic slot_mem;
  logic slot_done;
  logic abort_hit;

  // DONE: non-memory op, or memory op acked this cycle; ack without a request is ignored.
  assign slot_mem  = slot_vld_q & (slot_q.ld | slot_q.st);
  assign slot_done = slot_vld_q & (~slot_mem | i_memctrl_ack);
  assign abort_hit = slot_mem & i_memctrl_ack & i_memctrl_abort;
  assign o_mem_rdy = ~slot_vld_q | slot_done;

  always_comb begin
    slot_d         = slot_q;
    slot_d.op      = i_mem_op;
    slot_d.wdata   = i_mem_wdata;
    slot_d.ld      = i_mem_ld;
    slot_d.st      = i_mem_st;
    slot_d.size    = i_mem_size;
    slot_d.sign    = i_mem_sign;
    slot_d.rd_vld  = i_mem_rd_vld;
    slot_d.rd_code = i_mem_rd_code;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      slot_q       <= '0;
      slot_vld_q   <= 1'b0;
      wb_op_q      <= '0;
      wb_rd_src_q  <= 1'b0;
      wb_rd_vld_q  <= 1'b0;
      wb_rd_code_q <= '0;
      dabort_q     <= 1'b0;
    end else begin
      if (slot_done) begin
        wb_op_q      <= slot_q.op;
        wb_rd_src_q  <= slot_q.ld;
        wb_rd_code_q <= slot_q.rd_code;
        wb_rd_vld_q  <= slot_q.rd_vld & ~abort_hit;
      end else begin
        wb_rd_vld_q  <= 1'b0;
      end
      dabort_q <= slot_done & abort_hit;
      if (o_mem_rdy) begin
        slot_vld_q <= i_mem_vld;
        if (i_mem_vld) slot_q <= slot_d;
      end
    end
  end

  assign o_memctrl_req  = slot_mem;
  assign o_memctrl_we   = slot_q.st;
  assign o_memctrl_addr = slot_q.op;
  assign o_memctrl_size = slot_q.size;
  assign o_memctrl_sign = slot_q.sign;

  mem_stage_st_lane_rep u_lane_rep (
    .size_i  (slot_q.size),
    .wdata_i (slot_q.wdata),
    .wdata_o (o_memctrl_wdata)
  );

  assign o_wb_op      = wb_op_q;
  assign o_wb_rd_src  = wb_rd_src_q;
  assign o_wb_rd_vld  = wb_rd_vld_q;
  assign o_wb_rd_code = wb_rd_code_q;
  assign o_dabort     = dabort_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus a randomized run checked
// against an instruction-level reference model.
module tb_mem_stage;

  typedef struct packed {
    logic [31:0] op;
    logic [31:0] wdata;
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        sign;
    logic        rd_vld;
    logic [3:0]  rd_code;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld, ack, abort;
  instr_t      cur;
  logic        mem_rdy, req, we, sign_o, wb_src, wb_vld, dabort;
  logic [31:0] addr, wdata_o, wb_op;
  logic [1:0]  size_o;
  logic [3:0]  wb_code;

  int n_pass = 0;
  int n_total = 0;

  // reference model: instruction held by the stage and expected write-back outputs
  logic        m_has;
  instr_t      m_ins;
  logic [31:0] e_op;
  logic        e_src, e_vld, e_dab;
  logic [3:0]  e_code;

  always #5 clk = ~clk;

  mem_stage dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mem_vld(in_vld), .o_mem_rdy(mem_rdy),
    .i_mem_op(cur.op), .i_mem_wdata(cur.wdata), .i_mem_ld(cur.ld), .i_mem_st(cur.st),
    .i_mem_size(cur.size), .i_mem_sign(cur.sign),
    .i_mem_rd_vld(cur.rd_vld), .i_mem_rd_code(cur.rd_code),
    .o_memctrl_req(req), .o_memctrl_we(we), .o_memctrl_addr(addr),
    .o_memctrl_wdata(wdata_o), .o_memctrl_size(size_o), .o_memctrl_sign(sign_o),
    .i_memctrl_ack(ack), .i_memctrl_abort(abort),
    .o_wb_op(wb_op), .o_wb_rd_src(wb_src), .o_wb_rd_vld(wb_vld),
    .o_wb_rd_code(wb_code), .o_dabort(dabort)
  );

  function automatic instr_t mk(input logic [31:0] op, input logic [31:0] wd,
                                input logic ld, input logic st, input logic [1:0] sz,
                                input logic rdv, input logic [3:0] rdc);
    instr_t x;
    x.op = op; x.wdata = wd; x.ld = ld; x.st = st; x.size = sz;
    x.sign = 1'b0; x.rd_vld = rdv; x.rd_code = rdc;
    return x;
  endfunction

  function automatic logic [31:0] rep(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'd0) return (w & 32'h0000_00FF) * 32'h0101_0101;
    if (sz == 2'd1) return (w & 32'h0000_FFFF) * 32'h0001_0001;
    return w;
  endfunction

  task automatic drive(input logic v, input instr_t x, input logic a, input logic ab);
    in_vld = v; cur = x; ack = a; abort = ab;
    #1;
  endtask

  task automatic model_edge();
    logic is_mem, fin, ab;
    if (!rst_n) begin
      m_has = 0; m_ins = '0; e_op = 0; e_src = 0; e_vld = 0; e_dab = 0; e_code = 0;
      return;
    end
    is_mem = m_has && (m_ins.ld || m_ins.st);
    fin    = m_has && (!is_mem || ack);
    ab     = is_mem && ack && abort;
    if (fin) begin
      e_op = m_ins.op; e_src = m_ins.ld; e_code = m_ins.rd_code;
      e_vld = m_ins.rd_vld && !ab;
    end else begin
      e_vld = 0;
    end
    e_dab = fin && ab;
    if (!m_has || fin) begin
      m_has = in_vld;
      if (in_vld) m_ins = cur;
    end
  endtask

  // advance one clock; ends 1 time unit after the rising edge
  task automatic cycle();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      cycle();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    cycle(); cycle();
    n_total++; if ({req, wb_vld, wb_src, dabort} !== 4'b0) $display("FAIL reset_ctl got %b exp 0000", {req, wb_vld, wb_src, dabort}); else n_pass++;
    n_total++; if (wb_op !== 32'h0 || wb_code !== 4'h0) $display("FAIL reset_wb got op=%h code=%h exp 0", wb_op, wb_code); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++; if (mem_rdy !== 1'b1) $display("FAIL reset_rdy got %b exp 1", mem_rdy); else n_pass++;
  endtask

  task automatic test_alu();
    drive(1'b1, mk(32'h0000_1234, 32'h0, 0, 0, 2'd2, 1, 4'd3), 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_total++; if (req !== 1'b0 || mem_rdy !== 1'b1) $display("FAIL alu_noreq got req=%b rdy=%b exp 0/1", req, mem_rdy); else n_pass++;
    cycle();
    n_total++;
    if (wb_op !== 32'h1234 || wb_vld !== 1'b1 || wb_code !== 4'd3 || wb_src !== 1'b0)
      $display("FAIL alu_wb got op=%h vld=%b code=%0d src=%b exp 1234/1/3/0", wb_op, wb_vld, wb_code, wb_src);
    else n_pass++;
    idle(2);
  endtask

  task automatic test_load_wait();
    drive(1'b1, mk(32'h100, 32'h0, 1, 0, 2'd2, 1, 4'd5), 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, (i == 3), 1'b0);
      n_total++;
      if (req !== 1'b1 || addr !== 32'h100 || we !== 1'b0 || mem_rdy !== (i == 3))
        $display("FAIL ldwait_req%0d got req=%b addr=%h we=%b rdy=%b", i, req, addr, we, mem_rdy);
      else n_pass++;
      cycle();
      if (i < 3) begin
        n_total++; if (wb_vld !== 1'b0) $display("FAIL ldwait_bubble%0d got %b exp 0", i, wb_vld); else n_pass++;
      end
    end
    n_total++;
    if (wb_vld !== 1'b1 || wb_src !== 1'b1 || wb_code !== 4'd5)
      $display("FAIL ldwait_wb got vld=%b src=%b code=%0d exp 1/1/5", wb_vld, wb_src, wb_code);
    else n_pass++;
    idle(1);
  endtask

  task automatic test_store_lanes();
    logic [31:0] wd [4] = '{32'h0000_00AB, 32'h1234_BEEF, 32'hCAFE_F00D, 32'h8765_4321};
    logic [31:0] ex [4] = '{32'hABAB_ABAB, 32'hBEEF_BEEF, 32'hCAFE_F00D, 32'h8765_4321};
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, mk(32'h203, wd[s], 0, 1, 2'(s), 0, 4'd0), 1'b0, 1'b0);
      cycle();
      drive(1'b0, '0, 1'b1, 1'b0);
      n_total++;
      if (wdata_o !== ex[s] || size_o !== 2'(s) || we !== 1'b1 || addr !== 32'h203 || req !== 1'b1)
        $display("FAIL store_sz%0d got wdata=%h size=%0d we=%b addr=%h exp %h", s, wdata_o, size_o, we, addr, ex[s]);
      else n_pass++;
      cycle();
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    instr_t seq [3];
    seq[0] = mk(32'h40, 32'h0, 1, 0, 2'd2, 1, 4'd1);
    seq[1] = mk(32'h77, 32'h0, 0, 0, 2'd2, 1, 4'd2);
    seq[2] = mk(32'h80, 32'h55, 0, 1, 2'd2, 1, 4'd4);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, seq[i], 1'b1, 1'b0);
      else drive(1'b0, '0, 1'b1, 1'b0);
      n_total++; if (mem_rdy !== 1'b1) $display("FAIL b2b_rdy%0d got %b exp 1", i, mem_rdy); else n_pass++;
      cycle();
      if (i >= 1 && i <= 3) begin
        n_total++;
        if (wb_vld !== 1'b1 || wb_code !== seq[i-1].rd_code || wb_src !== seq[i-1].ld || wb_op !== seq[i-1].op)
          $display("FAIL b2b_wb%0d got vld=%b code=%0d src=%b op=%h", i - 1, wb_vld, wb_code, wb_src, wb_op);
        else n_pass++;
      end
    end
    idle(1);
  endtask

  task automatic test_abort();
    drive(1'b1, mk(32'h300, 32'h0, 1, 0, 2'd2, 1, 4'd7), 1'b0, 1'b0);
    cycle();
    drive(1'b1, mk(32'h9999, 32'h0, 0, 0, 2'd2, 1, 4'd9), 1'b1, 1'b1);
    cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_total++;
    if (dabort !== 1'b1 || wb_vld !== 1'b0 || wb_code !== 4'd7 || wb_src !== 1'b1)
      $display("FAIL abort_pulse got dab=%b vld=%b code=%0d src=%b exp 1/0/7/1", dabort, wb_vld, wb_code, wb_src);
    else n_pass++;
    cycle();
    n_total++;
    if (dabort !== 1'b0 || wb_vld !== 1'b1 || wb_code !== 4'd9 || wb_op !== 32'h9999)
      $display("FAIL abort_next got dab=%b vld=%b code=%0d op=%h exp 0/1/9/9999", dabort, wb_vld, wb_code, wb_op);
    else n_pass++;
    idle(1);
  endtask

  task automatic test_reset_midaccess();
    drive(1'b1, mk(32'h400, 32'h0, 1, 0, 2'd2, 1, 4'd6), 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b0, 1'b0);
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    n_total++;
    if (req !== 1'b0 || wb_vld !== 1'b0 || mem_rdy !== 1'b1)
      $display("FAIL rst_mid got req=%b vld=%b rdy=%b exp 0/0/1", req, wb_vld, mem_rdy);
    else n_pass++;
    cycle();
    n_total++;
    if (wb_vld !== 1'b0 || dabort !== 1'b0 || req !== 1'b0)
      $display("FAIL rst_lateack got vld=%b dab=%b req=%b exp 0/0/0", wb_vld, dabort, req);
    else n_pass++;
    idle(1);
  endtask

  task automatic test_random();
    instr_t x;
    int kind;
    logic is_mem;
    for (int c = 0; c < 600; c++) begin
      kind = $urandom_range(0, 2);
      x.op = $urandom(); x.wdata = $urandom();
      x.ld = (kind == 1); x.st = (kind == 2);
      x.size = 2'($urandom_range(0, 3)); x.sign = 1'($urandom());
      x.rd_vld = 1'($urandom()); x.rd_code = 4'($urandom());
      rst_n = ($urandom_range(0, 99) != 0);
      drive(($urandom_range(0, 9) < 7), x, 1'($urandom()), ($urandom_range(0, 3) == 0));
      is_mem = m_has && (m_ins.ld || m_ins.st);
      n_total++;
      if (mem_rdy !== (!is_mem || ack) || req !== is_mem)
        $display("FAIL rnd_hs c=%0d got rdy=%b req=%b exp %b/%b", c, mem_rdy, req, !is_mem || ack, is_mem);
      else n_pass++;
      if (is_mem) begin
        n_total++;
        if (addr !== m_ins.op || we !== m_ins.st || wdata_o !== rep(m_ins.size, m_ins.wdata) ||
            size_o !== m_ins.size || sign_o !== m_ins.sign)
          $display("FAIL rnd_ctrl c=%0d got addr=%h we=%b wd=%h sz=%0d exp %h/%b/%h/%0d",
                   c, addr, we, wdata_o, size_o, m_ins.op, m_ins.st, rep(m_ins.size, m_ins.wdata), m_ins.size);
        else n_pass++;
      end
      cycle();
      n_total++;
      if (wb_vld !== e_vld || dabort !== e_dab || wb_op !== e_op || wb_src !== e_src || wb_code !== e_code)
        $display("FAIL rnd_wb c=%0d got vld=%b dab=%b op=%h src=%b code=%0d exp %b/%b/%h/%b/%0d",
                 c, wb_vld, dabort, wb_op, wb_src, wb_code, e_vld, e_dab, e_op, e_src, e_code);
      else n_pass++;
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; cur = '0; ack = 1'b0; abort = 1'b0;
    m_has = 0; m_ins = '0; e_op = 0; e_src = 0; e_vld = 0; e_dab = 0; e_code = 0;
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_load_wait();
    test_store_lanes();
    test_back_to_back();
    test_abort();
    test_reset_midaccess();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
